// File: rtl/zxuno_option_bank_pkg.sv
// rtl/zxuno_option_bank_pkg.sv - ZX-Uno option register addresses, build masks and value filter
package zxuno_option_bank_pkg;

  localparam logic [7:0] DEVOPTIONS = 8'h0E;
  localparam logic [7:0] DEVOPTS2   = 8'h0F;
  localparam logic [7:0] OPTLOCK    = 8'h0D;

  // Features compiled out of the build read back as fixed bits.
`ifdef ZXUNO_NO_RADASTAN
  localparam logic [15:0] BUILD_IMPLMASK = 16'h3FBF;
`else
  localparam logic [15:0] BUILD_IMPLMASK = 16'h3FFF;
`endif
  localparam logic [15:0] BUILD_FORCEVAL = 16'h8000;

  function automatic logic [7:0] opt_filter(input logic [7:0] v,
                                            input logic [7:0] impl,
                                            input logic [7:0] force_v);
    return (v & impl) | (force_v & ~impl);
  endfunction

endpackage

// File: rtl/zxuno_option_bank_option_reg_slot.sv
// rtl/zxuno_option_bank_option_reg_slot.sv - one option register: staged value, active value, pending and change flags
module option_reg_slot
  import zxuno_option_bank_pkg::*;
#(
  parameter logic [7:0] IMPL  = 8'hFF,
  parameter logic [7:0] FORCE = 8'h00,
  parameter logic [7:0] RST   = 8'h00,
  parameter bit         DEFER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       commit,
  output logic [7:0] stage,
  output logic [7:0] opt,
  output logic       pend,
  output logic       changed
);

  logic [7:0] wval;
  logic [7:0] stage_next;
  logic [7:0] opt_next;
  logic       pend_next;

  always_comb begin
    wval       = opt_filter(wdata, IMPL, FORCE);
    stage_next = wr_en ? wval : stage;
    opt_next   = opt;
    pend_next  = 1'b0;
    if (DEFER) begin
      // Commit applies the pre-edge stage, so a concurrent write stays pending.
      if (commit && pend) opt_next = stage;
      pend_next = wr_en | (pend & ~commit);
    end else if (wr_en) begin
      opt_next = wval;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage   <= opt_filter(RST, IMPL, FORCE);
      opt     <= opt_filter(RST, IMPL, FORCE);
      pend    <= 1'b0;
      changed <= 1'b0;
    end else begin
      stage   <= stage_next;
      opt     <= opt_next;
      pend    <= pend_next;
      changed <= (opt_next != opt);
    end
  end

endmodule

// File: rtl/zxuno_option_bank.sv
// rtl/zxuno_option_bank.sv - bank of ZX-Uno option registers with masks, deferred commit and write lock
module zxuno_option_bank
  import zxuno_option_bank_pkg::*;
#(
  parameter int                NREGS     = 2,
  parameter logic [7:0]        BASEADDR  = DEVOPTIONS,
  parameter logic [7:0]        LOCKADDR  = OPTLOCK,
  parameter logic [NREGS*8-1:0] RSTVAL   = {NREGS{8'h00}},
  parameter logic [NREGS*8-1:0] IMPLMASK = {NREGS{8'hFF}},
  parameter logic [NREGS*8-1:0] FORCEVAL = {NREGS{8'h00}},
  parameter logic [NREGS-1:0]   DEFERMASK = {NREGS{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         zxuno_addr,
  input  logic               zxuno_regrd,
  input  logic               zxuno_regwr,
  input  logic [7:0]         din,
  input  logic               commit,
  output logic [7:0]         dout,
  output logic               oe,
  output logic [NREGS*8-1:0] options,
  output logic [NREGS-1:0]   changed,
  output logic               pending,
  output logic               locked
);

  logic [7:0]       stage [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] wr_en;

  for (genvar g = 0; g < NREGS; g++) begin : g_slot
    assign wr_en[g] = zxuno_regwr && !locked && (zxuno_addr == 8'(BASEADDR + g));

    option_reg_slot #(
      .IMPL  (IMPLMASK[8*g +: 8]),
      .FORCE (FORCEVAL[8*g +: 8]),
      .RST   (RSTVAL[8*g +: 8]),
      .DEFER (DEFERMASK[g])
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[g]),
      .wdata   (din),
      .commit  (commit),
      .stage   (stage[g]),
      .opt     (options[8*g +: 8]),
      .pend    (pend[g]),
      .changed (changed[g])
    );
  end

  // Lock is sticky until reset; the pre-edge lock state gates same-cycle register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (zxuno_regwr && (zxuno_addr == LOCKADDR) && din[0]) begin
      locked <= 1'b1;
    end
  end

  assign pending = |pend;

  always_comb begin
    oe   = 1'b0;
    dout = 8'hFF;
    if (zxuno_regrd) begin
      if (zxuno_addr == LOCKADDR) begin
        oe   = 1'b1;
        dout = {6'b0, pending, locked};
      end
      for (int i = 0; i < NREGS; i++) begin
        if (zxuno_addr == 8'(BASEADDR + i)) begin
          oe   = 1'b1;
          dout = stage[i];
        end
      end
    end
  end

endmodule
